// File: rtl/resp_tx_framer_pkg.sv
// resp_tx_pkg: shared types and helpers for the response TX framer.
// Optional checksum byte is enabled by defining RESP_CHECKSUM_EN.
package resp_tx_pkg;

    // Framer FSM states; CSUM is only reachable when RESP_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        IDLE,
        SOF,
        DATA,
        CSUM,
        DONE
    } resp_tx_state_t;

    // Default start-of-frame marker.
    localparam logic [7:0] RESP_SOF_BYTE = 8'hA5;

    // Payload bytes carried by one response word.
    function automatic int resp_nbytes(input int resp_w);
        return resp_w / 8;
    endfunction

endpackage

// File: rtl/resp_tx_framer_if.sv
// resp_tx_framer_if: response FIFO read port plus byte handshake to uart_tx.
// master = framer side, slave = FIFO/UART environment side.
interface resp_tx_framer_if #(
    parameter int RESP_W = 32
) ();
    import resp_tx_pkg::*;

    logic              resp_fifo_empty;
    logic [RESP_W-1:0] resp_fifo_data;
    logic              resp_fifo_rd_en;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        input  resp_fifo_empty,
        input  resp_fifo_data,
        input  tx_ready,
        output resp_fifo_rd_en,
        output tx_data,
        output tx_valid
    );

    modport slave (
        output resp_fifo_empty,
        output resp_fifo_data,
        output tx_ready,
        input  resp_fifo_rd_en,
        input  tx_data,
        input  tx_valid
    );

endinterface

// File: rtl/resp_tx_framer_byte_serializer.sv
// byte_serializer: holds the popped response word, walks it out MSB first,
// and owns the registered valid/data pair presented to uart_tx.
// A presented byte is held until accepted; valid then drops for one cycle
// before the next byte is registered, so each byte costs at least 2 cycles.
module byte_serializer
    import resp_tx_pkg::*;
#(
    parameter int RESP_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,       // capture load_word, restart byte index
    input  logic [RESP_W-1:0] load_word,
    input  logic              offer,      // FSM wants a byte presented
    input  logic              payload,    // present shift-register MSB (else aux_byte)
    input  logic [7:0]        aux_byte,   // SOF or checksum byte
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              xfer,       // byte accepted this cycle
    output logic              last_done   // final payload byte accepted this cycle
);

    localparam int NB    = resp_nbytes(RESP_W);
    localparam int IDX_W = $clog2(NB + 1);

    logic [RESP_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;

    assign xfer      = tx_valid && tx_ready;
    assign last_done = xfer && payload && (idx == IDX_W'(NB - 1));

    // Payload shift register and byte index; advance only on accepted payload bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            idx   <= '0;
        end else if (load) begin
            shreg <= load_word;
            idx   <= '0;
        end else if (xfer && payload) begin
            shreg <= shreg << 8;
            idx   <= idx + 1'b1;
        end
    end

    // Output holding register: hold until accepted, then one empty cycle, then next byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (tx_valid) begin
            if (tx_ready)
                tx_valid <= 1'b0;
        end else if (offer) begin
            tx_valid <= 1'b1;
            tx_data  <= payload ? shreg[RESP_W-1 -: 8] : aux_byte;
        end
    end

endmodule

// File: rtl/resp_tx_framer.sv
// resp_tx_framer: pops 32-bit responses from the response FIFO and frames
// them as SOF, payload bytes MSB first, and (optionally) an XOR checksum byte.
// Define RESP_CHECKSUM_EN to append the checksum byte to every frame.
module resp_tx_framer
    import resp_tx_pkg::*;
#(
    parameter int          RESP_W   = 32,
    parameter logic [7:0]  SOF_BYTE = RESP_SOF_BYTE,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    resp_tx_framer_if.master  bus,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    resp_tx_state_t state, nstate;
    logic           load;
    logic           offer;
    logic           payload;
    logic           xfer;
    logic           last_done;
    logic [7:0]     aux_byte;

    byte_serializer #(
        .RESP_W (RESP_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_word (bus.resp_fifo_data),
        .offer     (offer),
        .payload   (payload),
        .aux_byte  (aux_byte),
        .tx_ready  (bus.tx_ready),
        .tx_valid  (bus.tx_valid),
        .tx_data   (bus.tx_data),
        .xfer      (xfer),
        .last_done (last_done)
    );

`ifdef RESP_CHECKSUM_EN
    logic [7:0] csum;

    // XOR of the payload bytes of the current frame, restarted every IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            csum <= 8'h00;
        else if (state == IDLE)
            csum <= 8'h00;
        else if (xfer && state == DATA)
            csum <= csum ^ bus.tx_data;
    end

    assign aux_byte = (state == CSUM) ? csum : SOF_BYTE;
`else
    assign aux_byte = SOF_BYTE;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nstate;
    end

    // Next state and serializer controls.
    always_comb begin
        nstate  = state;
        load    = 1'b0;
        offer   = 1'b0;
        payload = 1'b0;
        case (state)
            IDLE: begin
                // Pop and capture the FIFO head in the same cycle.
                if (!bus.resp_fifo_empty) begin
                    load   = 1'b1;
                    nstate = SOF;
                end
            end
            SOF: begin
                offer = 1'b1;
                if (xfer)
                    nstate = DATA;
            end
            DATA: begin
                offer   = 1'b1;
                payload = 1'b1;
                if (last_done)
`ifdef RESP_CHECKSUM_EN
                    nstate = CSUM;
`else
                    nstate = DONE;
`endif
            end
`ifdef RESP_CHECKSUM_EN
            CSUM: begin
                offer = 1'b1;
                if (xfer)
                    nstate = DONE;
            end
`endif
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Completed-frame counter; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_cnt <= '0;
        else if (state == DONE)
            frame_cnt <= frame_cnt + 1'b1;
    end

    // Gated by rst so a held reset never pops the FIFO.
    assign bus.resp_fifo_rd_en = load && !rst;
    assign busy                = (state != IDLE);

endmodule

// File: tb/tb_resp_tx_framer.sv
// Directed self-checking bench for resp_tx_framer.
module tb_resp_tx_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] frame_cnt;

    resp_tx_framer_if #(.RESP_W(32)) bus ();

    resp_tx_framer #(
        .RESP_W   (32),
        .SOF_BYTE (8'hA5),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // FIFO model: words appended by tests, head advances once per observed pop.
    logic [31:0] wq[$];
    // Bytes accepted on the UART side, in order.
    logic [7:0]  rxq[$];
    int          rd_cnt   = 0;
    int          fifo_err = 0;
    int          gap_err  = 0;
    int          stab_err = 0;
    bit          prev_hold = 1'b0;
    bit          prev_xfer = 1'b0;
    logic [7:0]  prev_byte = 8'h00;

    always @(negedge clk) begin
        bus.resp_fifo_empty = (rd_cnt >= wq.size());
        bus.resp_fifo_data  = (rd_cnt < wq.size()) ? wq[rd_cnt] : 32'h0;
    end

    always @(posedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
            prev_xfer = 1'b0;
        end else begin
            if (prev_xfer && bus.tx_valid) gap_err++;
            if (prev_hold && (!bus.tx_valid || bus.tx_data !== prev_byte)) stab_err++;
            if (bus.tx_valid && bus.tx_ready) rxq.push_back(bus.tx_data);
            if (bus.resp_fifo_rd_en) begin
                rd_cnt++;
                if (bus.resp_fifo_empty) fifo_err++;
            end
            prev_hold = bus.tx_valid && !bus.tx_ready;
            prev_xfer = bus.tx_valid && bus.tx_ready;
            prev_byte = bus.tx_data;
        end
    end

    task automatic wait_cnt(input logic [15:0] target, output bit timeout);
        int n = 0;
        while (frame_cnt !== target && n < 400) begin
            @(negedge clk);
            n++;
        end
        timeout = (frame_cnt !== target);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.tx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (frame_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0000", frame_cnt); end
        total++; if (bus.resp_fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", bus.resp_fifo_rd_en); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", bus.tx_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int base = rxq.size();
        int rd0  = rd_cnt;
        int g0   = gap_err;
        bit to;
        logic [7:0] got;
        logic [7:0] exp[$] = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef RESP_CHECKSUM_EN
        exp.push_back(8'h22);
`endif
        bus.tx_ready = 1'b1;
        wq.push_back(32'hDEADBEEF);
        wait_cnt(16'd1, to);
        total++; if (to) begin bad++; $display("FAIL single_timeout: frame_cnt %h want 0001", frame_cnt); end
        total++; if (rxq.size() - base != exp.size()) begin bad++; $display("FAIL single_len: got %0d want %0d", rxq.size() - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            got = (base + i < rxq.size()) ? rxq[base + i] : 8'hxx;
            total++; if (got !== exp[i]) begin bad++; $display("FAIL single_byte%0d: got %h want %h", i, got, exp[i]); end
        end
        total++; if (rd_cnt - rd0 != 1) begin bad++; $display("FAIL single_rd_pulses: got %0d want 1", rd_cnt - rd0); end
        total++; if (gap_err != g0) begin bad++; $display("FAIL single_gap: got %0d want %0d", gap_err, g0); end
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || bus.tx_valid !== 1'b0) begin bad++; $display("FAIL single_idle: busy %b valid %b want 0 0", busy, bus.tx_valid); end
    endtask

    task automatic test_back_to_back();
        int base = rxq.size();
        int rd0  = rd_cnt;
        bit to;
        logic [7:0] got;
        logic [7:0] exp[$] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01};
`ifdef RESP_CHECKSUM_EN
        exp.push_back(8'h01);
`endif
        exp.push_back(8'hA5); exp.push_back(8'h12); exp.push_back(8'h34);
        exp.push_back(8'h56); exp.push_back(8'h78);
`ifdef RESP_CHECKSUM_EN
        exp.push_back(8'h08);
`endif
        bus.tx_ready = 1'b1;
        wq.push_back(32'h00000001);
        wq.push_back(32'h12345678);
        wait_cnt(16'd3, to);
        total++; if (to) begin bad++; $display("FAIL b2b_timeout: frame_cnt %h want 0003", frame_cnt); end
        total++; if (rxq.size() - base != exp.size()) begin bad++; $display("FAIL b2b_len: got %0d want %0d", rxq.size() - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            got = (base + i < rxq.size()) ? rxq[base + i] : 8'hxx;
            total++; if (got !== exp[i]) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp[i]); end
        end
        total++; if (rd_cnt - rd0 != 2) begin bad++; $display("FAIL b2b_rd_pulses: got %0d want 2", rd_cnt - rd0); end
    endtask

    task automatic test_backpressure();
        int base = rxq.size();
        int s0   = stab_err;
        int k    = 0;
        bit to;
        logic [7:0]  got;
        logic [15:0] pat = 16'b1011_0010_0110_1001;
        logic [7:0] exp[$] = '{8'hA5, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
`ifdef RESP_CHECKSUM_EN
        exp.push_back(8'hC9);
`endif
        wq.push_back(32'hCAFEF00D);
        while (rxq.size() - base < 3 && k < 300) begin
            @(negedge clk);
            bus.tx_ready = pat[k % 16];
            k++;
        end
        bus.tx_ready = 1'b0;
        repeat (50) @(negedge clk);
        total++; if (bus.tx_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid: got %b want 1", bus.tx_valid); end
        total++; if (bus.tx_data !== 8'hF0) begin bad++; $display("FAIL bp_hold_data: got %h want f0", bus.tx_data); end
        total++; if (rxq.size() - base != 3) begin bad++; $display("FAIL bp_stall_count: got %0d want 3", rxq.size() - base); end
        bus.tx_ready = 1'b1;
        wait_cnt(16'd4, to);
        total++; if (to) begin bad++; $display("FAIL bp_timeout: frame_cnt %h want 0004", frame_cnt); end
        for (int i = 0; i < exp.size(); i++) begin
            got = (base + i < rxq.size()) ? rxq[base + i] : 8'hxx;
            total++; if (got !== exp[i]) begin bad++; $display("FAIL bp_byte%0d: got %h want %h", i, got, exp[i]); end
        end
        total++; if (stab_err != s0) begin bad++; $display("FAIL bp_stable: %0d unstable holds want 0", stab_err - s0); end
    endtask

    task automatic test_empty();
        int rd0 = rd_cnt;
        int errs = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.resp_fifo_rd_en !== 1'b0 || bus.tx_valid !== 1'b0 || busy !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL empty_quiet: %0d active cycles want 0", errs); end
        total++; if (rd_cnt != rd0) begin bad++; $display("FAIL empty_rd: got %0d pops want 0", rd_cnt - rd0); end
        total++; if (fifo_err != 0) begin bad++; $display("FAIL empty_pop_on_empty: got %0d want 0", fifo_err); end
    endtask

    task automatic test_reset_mid();
        int base = rxq.size();
        int k = 0;
        bit to;
        logic [7:0] got;
        logic [7:0] exp[$] = '{8'hA5, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
`ifdef RESP_CHECKSUM_EN
        exp.push_back(8'h5B);
`endif
        bus.tx_ready = 1'b1;
        wq.push_back(32'h11223344);
        while ((rxq.size() - base < 3 || bus.tx_valid !== 1'b1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        total++; if (k >= 100) begin bad++; $display("FAIL rmid_reach: got %0d bytes want 3", rxq.size() - base); end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", bus.tx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        base = rxq.size();
        wq.push_back(32'h0BADF00D);
        wait_cnt(16'd1, to);
        total++; if (to) begin bad++; $display("FAIL rmid_timeout: frame_cnt %h want 0001", frame_cnt); end
        total++; if (rxq.size() - base != exp.size()) begin bad++; $display("FAIL rmid_len: got %0d want %0d", rxq.size() - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            got = (base + i < rxq.size()) ? rxq[base + i] : 8'hxx;
            total++; if (got !== exp[i]) begin bad++; $display("FAIL rmid_byte%0d: got %h want %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_wrap();
        bit to;
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        #1 release dut.frame_cnt;
        @(negedge clk);
        total++; if (frame_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload: got %h want ffff", frame_cnt); end
        bus.tx_ready = 1'b1;
        wq.push_back(32'h5A5A5A5A);
        wait_cnt(16'h0000, to);
        total++; if (to || frame_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_cnt: got %h want 0000", frame_cnt); end
    endtask

    initial begin
        bus.tx_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_empty();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
